sdram_wb_arbiter: RTL
=====================

// Module: sdram_wb_arbiter
// PURPOSE
//  Two-master WISHBONE arbiter that shares the single SDRAM port between the
//  CPU (M0) and a DMA/video requester (M1). Its slave side drives the EMS
//  address-translation stage, which feeds the SDRAM controller.
//  - Round-robin grant with a per-grant burst cap, so neither master starves.
//  - Holds a grant until the slave acks or the master abandons its cycle.
//
// PARAMETERS
//  MAX_BURST  4  max back-to-back acked cycles a master may keep while the other waits (>=1)
//  CNT_W      3  width of burst counter; must satisfy 2**CNT_W > MAX_BURST
//
// PORTS
//  wb_clk_i    in   1      single system clock
//  wb_rst_i    in   1      synchronous, active-high reset
//  m0_adr_i    in   19     M0 (CPU) word address [19:1]
//  m0_dat_i    in   16     M0 write data
//  m0_sel_i    in   2      M0 byte selects
//  m0_we_i     in   1      M0 write enable
//  m0_cyc_i    in   1      M0 cycle
//  m0_stb_i    in   1      M0 strobe
//  m0_ack_o    out  1      M0 acknowledge
//  m1_*        --   --     same set as m0_* for M1 (DMA/video)
//  m_dat_o     out  16     read data, fanned out to both masters (= s_dat_i)
//  s_adr_o     out  19     slave address [19:1], to the EMS translator sdram_adr_i
//  s_dat_o     out  16     slave write data
//  s_sel_o     out  2      slave byte selects
//  s_we_o      out  1      slave write enable
//  s_cyc_o     out  1      slave cycle
//  s_stb_o     out  1      slave strobe
//  s_dat_i     in   16     slave read data
//  s_ack_i     in   1      slave acknowledge
//  gnt_o       out  2      one-hot current grant {M1,M0}; 2'b00 when idle
//
// BEHAVIOUR
//  Request: req_n = mn_cyc_i & mn_stb_i.
//  States: IDLE, BUSY0, BUSY1. Registers: state, last (last master served), burst_cnt.
//  Reset: state=IDLE, last=1 (M0 wins the first tie), burst_cnt=0.
//    Outputs at reset: s_cyc_o=s_stb_o=0, m0/m1_ack_o=0, gnt_o=00.
//  IDLE:
//    - Only req0 -> BUSY0; only req1 -> BUSY1.
//    - Both -> grant the master != last.
//    - burst_cnt cleared on any grant.
//    - One cycle of arbitration latency: the slave is not driven while in IDLE.
//  BUSYn (combinational muxing from master n):
//    - s_adr/dat/sel/we follow master n.
//    - s_cyc_o = mn_cyc_i; s_stb_o = mn_stb_i.
//    - mn_ack_o = s_ack_i. The other master's ack is 0.
//    - gnt_o bit n = 1.
//  Abandon: mn_cyc_i=0 while in BUSYn -> s_cyc_o drops the same cycle; next state IDLE;
//    last=n; burst_cnt is not incremented.
//  On s_ack_i in BUSYn: last=n, burst_cnt++ (saturates at MAX_BURST). Next state:
//    - other master requesting and (burst_cnt+1 >= MAX_BURST or ~mn_cyc_i)
//      -> BUSYother directly; burst_cnt=0; no idle cycle.
//    - else mn_cyc_i=1 -> stay in BUSYn (pipelined/back-to-back cycles allowed).
//    - else -> IDLE.
//  Simultaneous ack and cyc drop by master n: treated as ack-with-~cyc.
//  Reset asserted mid-transfer: next edge forces IDLE. Any pending slave ack is
//    discarded; the masters must re-issue.
//  A master whose grant was pre-empted keeps cyc/stb asserted and is re-granted
//    by round-robin.
//  s_ack_i received in IDLE is ignored (no master ack generated).
//
// TESTING
//  1. Reset, then M0 read at 0x0A000 -> grant next cycle; s_adr_o=0x0A000;
//     m0_ack_o mirrors s_ack_i; m1_ack_o=0; gnt_o=01.
//  2. M0 and M1 request in the same cycle right after reset -> M0 granted first;
//     after its ack, M1 granted with no IDLE cycle.
//  3. M0 keeps cyc for 10 acked cycles, M1 requesting throughout, MAX_BURST=4 ->
//     grant sequence M0x4, M1, M0x4, ...; M1 never waits more than 4 acks.
//  4. M1 drops cyc before the ack -> s_cyc_o=0 the same cycle; next state IDLE;
//     a late s_ack_i does not reach either master.
//  5. wb_rst_i pulsed while BUSY1 with the ack pending -> state IDLE, gnt_o=00,
//     acks 0 on the next cycle.
//  6. Write, M1 sel=2'b10, dat=0xBEEF -> s_sel_o=10, s_dat_o=0xBEEF, s_we_o=1
//     while BUSY1.

Source files
------------

// File: rtl/sdram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wb_arbiter
// Brief    : Two-master WISHBONE round-robin arbiter with per-grant burst cap,
//            sharing one SDRAM slave port between CPU (M0) and DMA/video (M1).
// Revision : 1.0 - initial release
// ============================================================================
module sdram_wb_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic [18:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic [1:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic        m0_ack_o,

    input  logic [18:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic [1:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic        m1_ack_o,

    output logic [15:0] m_dat_o,

    output logic [18:0] s_adr_o,
    output logic [15:0] s_dat_o,
    output logic [1:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [15:0] s_dat_i,
    input  logic        s_ack_i,

    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    localparam logic [CNT_W:0]   BURST_LIM = MAX_BURST[CNT_W:0];
    localparam logic [CNT_W-1:0] BURST_CAP = MAX_BURST[CNT_W-1:0];

    state_t           state, state_nx;
    logic             last, last_nx;
    logic [CNT_W-1:0] burst_cnt, cnt_nx;

    logic             req0, req1;
    logic             cur, cur_cyc, oth_req;
    logic [CNT_W:0]   burst_inc;
    logic [CNT_W-1:0] burst_sat;

    assign req0      = m0_cyc_i & m0_stb_i;
    assign req1      = m1_cyc_i & m1_stb_i;
    assign cur       = (state == BUSY1);
    assign cur_cyc   = cur ? m1_cyc_i : m0_cyc_i;
    assign oth_req   = cur ? req0 : req1;
    assign burst_inc = {1'b0, burst_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign burst_sat = (burst_inc >= BURST_LIM) ? BURST_CAP : burst_inc[CNT_W-1:0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            burst_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        cnt_nx   = burst_cnt;
        case (state)
            IDLE: begin
                // On a tie, the master that was not served last wins.
                if (req0 && (!req1 || last)) begin
                    state_nx = BUSY0;
                    cnt_nx   = '0;
                end else if (req1) begin
                    state_nx = BUSY1;
                    cnt_nx   = '0;
                end
            end
            BUSY0, BUSY1: begin
                if (s_ack_i) begin
                    last_nx = cur;
                    if (oth_req && ((burst_inc >= BURST_LIM) || !cur_cyc)) begin
                        state_nx = cur ? BUSY0 : BUSY1;
                        cnt_nx   = '0;
                    end else if (cur_cyc) begin
                        cnt_nx = burst_sat;
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = burst_sat;
                    end
                end else if (!cur_cyc) begin
                    state_nx = IDLE;
                    last_nx  = cur;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state)
            BUSY0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_ack_o = s_ack_i;
            end
            BUSY1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

    assign gnt_o   = {state == BUSY1, state == BUSY0};
    assign m_dat_o = s_dat_i;

endmodule
`default_nettype wire
